seq_divider: RTL and testbench

- Multi-cycle restoring shift-subtract integer divider for the KGP-RISC ALU.
- Inverse of the shift-add multiplier: computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Sits beside the ALU; the control unit starts it and stalls until done.

---
 rtl/seq_divider.sv | 160 ++++++++++++++++
 tb/tb_seq_divider.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring shift-subtract divider, one quotient bit per clock
// Optional two's-complement mode when SIGNED_DIV_EN is defined (adds is_signed input).
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted_r;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   iter_r;
    logic [WIDTH-1:0]   iter_q;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;

    // One restoring step: shift {R,Q} left, trial-subtract D, keep the result if non-negative.
    assign shifted_r = {r_q, q_q[WIDTH-1]};
    assign diff      = shifted_r - {1'b0, d_q};
    assign iter_r    = diff[WIDTH] ? shifted_r[WIDTH-1:0] : diff[WIDTH-1:0];
    assign iter_q    = {q_q[WIDTH-2:0], ~diff[WIDTH]};

`ifdef SIGNED_DIV_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic dvd_neg, dvs_neg;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
    assign quo_fin = qneg_q ? (~iter_q + 1'b1) : iter_q;
    assign rem_fin = rneg_q ? (~iter_r + 1'b1) : iter_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (state_q == IDLE && start) begin
            qneg_d = dvd_neg ^ dvs_neg;
            rneg_d = dvd_neg;
        end
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign quo_fin = iter_q;
    assign rem_fin = iter_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d   = dvd_mag;
                    d_d   = dvs_mag;
                    r_d   = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor skips the iterations; results come straight from the raw operand.
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = iter_r;
                q_d   = iter_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    quo_d   = quo_fin;
                    rem_d   = rem_fin;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed-vector bench for seq_divider
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef SIGNED_DIV_EN
        .is_signed(is_signed),
`endif
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one division, track busy every cycle, and check latency, results and the hold afterwards.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                           input int elat, input logic poke);
        int   n;
        logic seen;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = ~a;
        divisor   = ~b;
        is_signed = ~sg;
        n    = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
            else chk("busy_run", {31'b0, busy}, 32'd1);
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
        chk("latency", n, elat);
        chk("busy_at_done", {31'b0, busy}, 32'd1);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, edbz});
        if (poke) begin
            start    = 1'b1;
            dividend = 32'd50;
            divisor  = 32'd5;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_single", {31'b0, done}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("quotient_hold", quotient, eq);
        chk("remainder_hold", remainder, er);
    endtask

    initial begin
        logic seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);

        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b1);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b0);
        run_div(32'd5, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd5, 1'b0, 33, 1'b0);
        run_div(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 1'b0);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33, 1'b0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 1'b0);

        // Reset in the middle of a run, after an ignored start while busy.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            if (c == 10) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            if (c == 11) start = 1'b0;
            if (c == 20) rst = 1'b1;
        end
        chk("no_done_mid_run", {31'b0, seen}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33, 1'b0);

`ifdef SIGNED_DIV_EN
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 1'b0);
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 1'b0);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
